// File: rtl/mac_tx_arb_pkg.sv
// Shared types and constants for the MAC TX frame arbiter.
// Symbol geometry is fixed here and is not a per-instance parameter.
package mac_tx_arb_pkg;

  localparam int N_SYMBOLS = 8;
  localparam int W_SYMBOL  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_XFER  = 3'b010,
    ST_FLUSH = 3'b100
  } arb_state_t;

  // Truncation beat: empty keep and zero payload, so the MAC sees a bad frame end
  localparam logic [N_SYMBOLS-1:0]              ARB_ABORT_TKEEP = '0;
  localparam logic [N_SYMBOLS*W_SYMBOL-1:0]     ARB_ABORT_TDATA = '0;

endpackage

// File: rtl/mac_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from pointer+1 (mod N_SRC). Independent of any stream protocol.
module rr_pick #(
  parameter int N_SRC = 3,
  parameter int W_SRC = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [W_SRC-1:0] pointer,
  output logic [N_SRC-1:0] winner,
  output logic [W_SRC-1:0] index,
  output logic             any
);

  int   cand;
  logic found;

  always_comb begin
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = (int'(pointer) + i) % N_SRC;
      if (!found && req[W_SRC'(cand)]) begin
        found = 1'b1;
        index = W_SRC'(cand);
      end
    end
  end

  assign any    = |req;
  assign winner = any ? (N_SRC'(1) << index) : '0;

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-granular round-robin arbiter in front of the MAC TX stream slave.
// A mid-frame source gap becomes a truncating tlast beat; the rest of that frame is flushed.
module mac_tx_arb
  import mac_tx_arb_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int W_SRC = $clog2(N_SRC)
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_clk_en,
  input  logic [N_SRC-1:0]                              i_src_en,
  input  logic [N_SRC-1:0]                              s_axis_tvalid,
  input  logic [N_SRC-1:0][N_SYMBOLS-1:0]               s_axis_tkeep,
  input  logic [N_SRC-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]                              s_axis_tlast,
  output logic [N_SRC-1:0]                              s_axis_tready,
  output logic                                          m_axis_tvalid,
  output logic [N_SYMBOLS-1:0]                          m_axis_tkeep,
  output logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]            m_axis_tdata,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  output logic [N_SRC-1:0]                              o_grant,
  output logic                                          o_busy,
  output logic                                          o_abort,
  output logic [W_SRC-1:0]                              o_abort_src
);

  arb_state_t       state_reg, state_next;
  logic [N_SRC-1:0] grant_reg, grant_next;
  logic [W_SRC-1:0] owner_reg, owner_next;
  logic [W_SRC-1:0] pointer_reg, pointer_next;
  logic [W_SRC-1:0] abort_src_reg, abort_src_next;
  logic             started_reg, started_next;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] pick_onehot;
  logic [W_SRC-1:0] pick_index;
  logic             pick_any;

  logic own_valid;
  logic own_last;
  logic gap;

  assign req = s_axis_tvalid & i_src_en;

  rr_pick #(
    .N_SRC (N_SRC),
    .W_SRC (W_SRC)
  ) u_rr_pick (
    .req     (req),
    .pointer (pointer_reg),
    .winner  (pick_onehot),
    .index   (pick_index),
    .any     (pick_any)
  );

  assign own_valid = s_axis_tvalid[owner_reg];
  assign own_last  = s_axis_tlast[owner_reg];
  // Only a gap after an accepted beat is a protocol break; before that we just wait
  assign gap = started_reg & m_axis_tready & ~own_valid & i_clk_en;

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    owner_next     = owner_reg;
    pointer_next   = pointer_reg;
    abort_src_next = abort_src_reg;
    started_next   = started_reg;
    m_axis_tvalid  = 1'b0;
    m_axis_tkeep   = '0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    s_axis_tready  = '0;
    o_abort        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pick_any && i_clk_en) begin
          grant_next   = pick_onehot;
          owner_next   = pick_index;
          started_next = 1'b0;
          state_next   = ST_XFER;
        end
      end

      ST_XFER: begin
        s_axis_tready[owner_reg] = m_axis_tready;
        if (gap) begin
          m_axis_tvalid  = 1'b1;
          m_axis_tlast   = 1'b1;
          m_axis_tkeep   = ARB_ABORT_TKEEP;
          m_axis_tdata   = ARB_ABORT_TDATA;
          o_abort        = 1'b1;
          abort_src_next = owner_reg;
          state_next     = ST_FLUSH;
        end else begin
          m_axis_tvalid = own_valid;
          m_axis_tkeep  = s_axis_tkeep[owner_reg];
          m_axis_tdata  = s_axis_tdata[owner_reg];
          m_axis_tlast  = own_last;
          if (i_clk_en && own_valid && m_axis_tready) begin
            if (own_last) begin
              pointer_next = owner_reg;
              grant_next   = '0;
              state_next   = ST_IDLE;
            end else begin
              started_next = 1'b1;
            end
          end
        end
      end

      ST_FLUSH: begin
        // Ready only on enabled cycles so a discarded tlast is never missed
        s_axis_tready[owner_reg] = i_clk_en;
        if (i_clk_en && own_valid && own_last) begin
          pointer_next = owner_reg;
          grant_next   = '0;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      owner_reg     <= '0;
      pointer_reg   <= W_SRC'(N_SRC - 1);
      abort_src_reg <= '0;
      started_reg   <= 1'b0;
    end else if (i_clk_en) begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      owner_reg     <= owner_next;
      pointer_reg   <= pointer_next;
      abort_src_reg <= abort_src_next;
      started_reg   <= started_next;
    end
  end

  assign o_grant     = grant_reg;
  assign o_busy      = (state_reg != ST_IDLE);
  // The aborting source is visible during the pulse itself, then held
  assign o_abort_src = o_abort ? owner_reg : abort_src_reg;

endmodule
